memory: RTL and testbench
=========================

# memory

Memory stage of the sequential Y86-64 processor. Performs the data-memory read or write selected by the instruction code once per execute-complete strobe. Returns the loaded value `valM`, flags out-of-range data accesses, and merges fetch and memory errors into the 2-bit processor status consumed by write-back and PC-update logic. It owns the data memory array.

## Interface

Parameters:
- `DEPTH`, 256: number of 64-bit data words; valid word addresses are 0..DEPTH-1.
- `AW`, 64: width of address operands (`valE`, `valA`).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `icode`  in  4  Y86 instruction code: 0 halt, 4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq; others perform no access.
- `valA`  in  64  store data (rmmovq/pushq); load address (ret/popq).
- `valE`  in  64  access address (rmmovq, mrmovq, pushq, call).
- `valP`  in  11  return address stored by call; zero-extended to 64 bits.
- `valM`  out  64  loaded word (registered).
- `imem_error`  in  1  fetch-stage address error.
- `instr_valid`  in  1  fetch-stage decoded a legal icode.
- `dmem_error`  out  1  data address out of range (registered).
- `stat`  out  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS (registered).
- `e_com`  in  1  execute-complete strobe; qualifies the access on the current edge.

## Operation

- Address and data selection:
  - Writes: rmmovq and pushq store `valA` at M[`valE`]; call stores zext(`valP`) at M[`valE`].
  - Reads: mrmovq loads M[`valE`]; ret and popq load M[`valA`].
- Addresses are word indices, not byte addresses.
- An address is out of range when it is >= DEPTH, using the full 64-bit compare.
  - An out-of-range access sets `dmem_error`.
  - An out-of-range write is suppressed.
  - An out-of-range read returns `valM` = 0.
- Non-memory icodes (including illegal ones):
  - no array access;
  - `valM` = 0;
  - `dmem_error` = 0.
- Status priority, highest first:
  - `imem_error` -> ADR;
  - `!instr_valid` -> INS;
  - `dmem_error` (this access) -> ADR;
  - icode == 0 -> HLT;
  - otherwise AOK.
- Fetch-side errors (`imem_error`, `!instr_valid`) suppress any memory write for that strobe.
- `stat` is sticky. Once it is non-AOK, further `e_com` strobes are ignored: no write, and all outputs hold. Only reset clears it.

## Timing

- Reset, asserted asynchronously: `valM` = 0, `dmem_error` = 0, `stat` = AOK (0).
- The array is not reset unless `DMEM_CLEAR_ON_RESET_EN` is defined.
- On a rising edge with `e_com` = 1 and `stat` = AOK:
  - the write is committed to the array;
  - `valM`, `dmem_error` and `stat` update.
- Latency is one cycle: outputs are valid after the edge that sampled `e_com`.
- Read-after-write to the same address on consecutive strobes returns the new data. The array is written on edge N and read on edge N+1.
- A single instruction never both reads and writes, so there is no same-edge hazard.
- With `e_com` = 0: no write, and all outputs hold their values.
- Reset asserted mid-operation:
  - outputs clear immediately;
  - an edge coinciding with `rst_n` low performs no write.

## Configuration

- `DMEM_CLEAR_ON_RESET_EN` defined: reset asynchronously zeroes all DEPTH words, in addition to the output registers.
- Not defined: array contents survive reset and are X at power-up. Only the output registers reset.

## Test plan

- Reset: drive `rst_n` = 0 -> `valM` = 0, `dmem_error` = 0, `stat` = 0. With the macro defined, mrmovq `valE` = 5 after reset -> `valM` = 0.
- Store/load: rmmovq (`icode` = 4, `valE` = 5, `valA` = 20, `e_com` pulse), then mrmovq (`icode` = 5, `valE` = 5) -> `valM` = 20. Then popq (`icode` = 11, `valA` = 5) -> `valM` = 20.
- Call/return:
  - call (`icode` = 8, `valE` = 5, `valP` = 30), then popq `valA` = 5 -> `valM` = 30;
  - ret (`icode` = 9, `valA` = 5) -> `valM` = 30.
- Strobe gating: rmmovq `valE` = 7, `valA` = 99 with `e_com` held 0 -> outputs unchanged. A later mrmovq `valE` = 7 does not return 99.
- Address error: mrmovq `valE` = 300 -> `dmem_error` = 1, `stat` = 2, `valM` = 0. A following rmmovq `valE` = 5, `valA` = 77 is ignored, and `stat` stays 2 until reset.
- Status priority, reset between cases:
  - `icode` = 0 -> `stat` = 1;
  - `instr_valid` = 0 -> `stat` = 3;
  - `imem_error` = 1 with `instr_valid` = 0 -> `stat` = 2;
  - `instr_valid` = 0 with rmmovq -> no write.

Source files
------------

// File: rtl/memory.sv
// memory -- data-memory stage of the sequential Y86-64 processor.
//
// On each execute-complete strobe (e_com), this stage performs the load or store
// selected by icode. It registers the loaded word and the out-of-range flag, and
// it folds fetch and data errors into the sticky processor status.
//
// Ports:
//   clk          system clock, rising-edge
//   rst_n        asynchronous active-low reset
//   icode        Y86 instruction code
//   valA         store data (rmmovq/pushq) or load address (ret/popq)
//   valE         access address (rmmovq/mrmovq/pushq/call)
//   valP         return address written by call, zero-extended to 64 bits
//   valM         registered load result
//   imem_error   fetch-stage address error
//   instr_valid  fetch decoded a legal icode
//   dmem_error   registered data-address-out-of-range flag
//   stat         registered status: 0 AOK, 1 HLT, 2 ADR, 3 INS
//   e_com        execute-complete strobe
//
// Configuration macro:
//   DMEM_CLEAR_ON_RESET_EN  when defined, reset also zeroes every word of the
//                           data array. When undefined, the array survives reset
//                           and powers up as X.

module memory #(
   parameter int DEPTH = 256,
   parameter int AW    = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    icode,
   input  logic [AW-1:0] valA,
   input  logic [AW-1:0] valE,
   input  logic [10:0]   valP,
   output logic [63:0]   valM,
   input  logic          imem_error,
   input  logic          instr_valid,
   output logic          dmem_error,
   output logic [1:0]    stat,
   input  logic          e_com
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [1:0] S_AOK = 2'd0;
   localparam logic [1:0] S_HLT = 2'd1;
   localparam logic [1:0] S_ADR = 2'd2;
   localparam logic [1:0] S_INS = 2'd3;

   logic [63:0]   mem_q [DEPTH];

   logic [63:0]   valm_q, valm_d;
   logic          dmem_error_q, dmem_error_d;
   logic [1:0]    stat_q, stat_d;

   logic          is_read;
   logic          is_write;
   logic [AW-1:0] addr;
   logic [IW-1:0] idx;
   logic [63:0]   wdata;
   logic          oob;
   logic          fetch_err;
   logic          update;
   logic          we;

   always_comb begin
      is_read   = (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
      is_write  = (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
      // ret/popq take their address from valA; every other access uses valE
      addr      = ((icode == I_RET) || (icode == I_POPQ)) ? valA : valE;
      idx       = addr[IW-1:0];
      wdata     = (icode == I_CALL) ? 64'(valP) : 64'(valA);
      // full-width compare so high address bits cannot alias into the array
      oob       = (is_read || is_write) && (addr >= DEPTH_W);
      fetch_err = imem_error || !instr_valid;
      // once stat leaves AOK, the stage freezes until reset
      update    = e_com && (stat_q == S_AOK);
      we        = update && is_write && !oob && !fetch_err;
   end

   always_comb begin
      valm_d       = valm_q;
      dmem_error_d = dmem_error_q;
      stat_d       = stat_q;
      if (update) begin
         valm_d       = (is_read && !oob) ? mem_q[idx] : 64'd0;
         dmem_error_d = oob;
         if (imem_error)
            stat_d = S_ADR;
         else if (!instr_valid)
            stat_d = S_INS;
         else if (oob)
            stat_d = S_ADR;
         else if (icode == I_HALT)
            stat_d = S_HLT;
         else
            stat_d = S_AOK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valm_q       <= 64'd0;
         dmem_error_q <= 1'b0;
         stat_q       <= S_AOK;
      end else begin
         valm_q       <= valm_d;
         dmem_error_q <= dmem_error_d;
         stat_q       <= stat_d;
      end
   end

`ifdef DMEM_CLEAR_ON_RESET_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= 64'd0;
      end else if (we) begin
         mem_q[idx] <= wdata;
      end
   end
`else
   // no reset on the array; rst_n still blocks a write on an edge taken during reset
   always_ff @(posedge clk) begin
      if (we && rst_n)
         mem_q[idx] <= wdata;
   end
`endif

   assign valM       = valm_q;
   assign dmem_error = dmem_error_q;
   assign stat       = stat_q;

endmodule

// File: tb/tb_memory.sv
module tb_memory;

   logic        clk;
   logic        rst_n;
   logic [3:0]  icode;
   logic [63:0] valA;
   logic [63:0] valE;
   logic [10:0] valP;
   logic [63:0] valM;
   logic        imem_error;
   logic        instr_valid;
   logic        dmem_error;
   logic [1:0]  stat;
   logic        e_com;

   int checks   = 0;
   int failures = 0;

   memory #(.DEPTH(256), .AW(64)) dut (
      .clk(clk), .rst_n(rst_n), .icode(icode), .valA(valA), .valE(valE),
      .valP(valP), .valM(valM), .imem_error(imem_error),
      .instr_valid(instr_valid), .dmem_error(dmem_error), .stat(stat),
      .e_com(e_com)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: word-addressed array plus "known" flags for X contents
   logic [63:0] ref_mem [256];
   bit          ref_known [256];
   logic [63:0] exp_valm;
   bit          exp_valm_known;
   logic        exp_derr;
   logic [1:0]  exp_stat;

   function automatic void model_reset();
      exp_valm       = 64'd0;
      exp_valm_known = 1'b1;
      exp_derr       = 1'b0;
      exp_stat       = 2'd0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]   = 64'd0;
         ref_known[i] = 1'b1;
      end
`endif
   endfunction

   function automatic void model_strobe(input logic [3:0] ic, input logic [63:0] a,
                                        input logic [63:0] e, input logic [10:0] p,
                                        input logic ime, input logic iv, input logic ec);
      bit          rd, wr, bad;
      logic [63:0] ad;
      if (!ec || exp_stat != 2'd0) return;
      rd  = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
      wr  = (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
      ad  = (ic == 4'd9 || ic == 4'd11) ? a : e;
      bad = (rd || wr) && (ad > 64'd255);
      if (wr && !bad && !ime && iv) begin
         ref_mem[ad[7:0]]   = (ic == 4'd8) ? {53'd0, p} : a;
         ref_known[ad[7:0]] = 1'b1;
      end
      if (rd && !bad) begin
         exp_valm       = ref_mem[ad[7:0]];
         exp_valm_known = ref_known[ad[7:0]];
      end else begin
         exp_valm       = 64'd0;
         exp_valm_known = 1'b1;
      end
      exp_derr = bad;
      if (ime)            exp_stat = 2'd2;
      else if (!iv)       exp_stat = 2'd3;
      else if (bad)       exp_stat = 2'd2;
      else if (ic == 4'd0) exp_stat = 2'd1;
      else                exp_stat = 2'd0;
   endfunction

   task automatic step(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [10:0] p, input logic ime, input logic iv, input logic ec);
      icode = ic; valA = a; valE = e; valP = p;
      imem_error = ime; instr_valid = iv; e_com = ec;
      @(posedge clk);
      model_strobe(ic, a, e, p, ime, iv, ec);
      #1;
      e_com = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; e_com = 1'b0; icode = 4'd1; valA = '0; valE = '0; valP = '0;
      imem_error = 1'b0; instr_valid = 1'b1;
      model_reset();
      #1;
      checks++; if (valM !== 64'd0) begin $display("FAIL reset_valM got=%0h exp=0", valM); failures++; end
      checks++; if (dmem_error !== 1'b0) begin $display("FAIL reset_dmem_error got=%b exp=0", dmem_error); failures++; end
      checks++; if (stat !== 2'd0) begin $display("FAIL reset_stat got=%0d exp=0", stat); failures++; end
      @(negedge clk);
      rst_n = 1'b1;
`ifdef DMEM_CLEAR_ON_RESET_EN
      step(4'd5, 64'd0, 64'd5, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== 64'd0) begin $display("FAIL reset_cleared_mem got=%0h exp=0", valM); failures++; end
`endif
   endtask

   task automatic test_store_load();
      step(4'd4, 64'd20, 64'd5, 11'd0, 1'b0, 1'b1, 1'b1);
      step(4'd5, 64'd0, 64'd5, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== 64'd20) begin $display("FAIL mrmovq_load got=%0d exp=20", valM); failures++; end
      step(4'd11, 64'd5, 64'd0, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== 64'd20) begin $display("FAIL popq_load got=%0d exp=20", valM); failures++; end
      checks++; if (stat !== 2'd0) begin $display("FAIL store_load_stat got=%0d exp=0", stat); failures++; end
   endtask

   task automatic test_call_ret();
      step(4'd8, 64'hDEAD, 64'd5, 11'd30, 1'b0, 1'b1, 1'b1);
      step(4'd11, 64'd5, 64'd0, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== 64'd30) begin $display("FAIL call_popq got=%0d exp=30", valM); failures++; end
      step(4'd9, 64'd5, 64'd0, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== 64'd30) begin $display("FAIL ret_load got=%0d exp=30", valM); failures++; end
   endtask

   task automatic test_strobe_gating();
      step(4'd4, 64'd11, 64'd7, 11'd0, 1'b0, 1'b1, 1'b1);
      step(4'd5, 64'd0, 64'd7, 11'd0, 1'b0, 1'b1, 1'b1);
      step(4'd4, 64'd99, 64'd7, 11'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (valM !== 64'd11) begin $display("FAIL gated_valM_hold got=%0d exp=11", valM); failures++; end
      checks++; if (stat !== 2'd0 || dmem_error !== 1'b0) begin
         $display("FAIL gated_status_hold got=%0d/%b exp=0/0", stat, dmem_error); failures++; end
      step(4'd5, 64'd0, 64'd7, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== 64'd11) begin $display("FAIL gated_no_write got=%0d exp=11", valM); failures++; end
   endtask

   task automatic test_addr_error();
      step(4'd5, 64'd0, 64'd300, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (dmem_error !== 1'b1) begin $display("FAIL oob_dmem_error got=%b exp=1", dmem_error); failures++; end
      checks++; if (stat !== 2'd2) begin $display("FAIL oob_stat got=%0d exp=2", stat); failures++; end
      checks++; if (valM !== 64'd0) begin $display("FAIL oob_valM got=%0h exp=0", valM); failures++; end
      step(4'd4, 64'd77, 64'd5, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (stat !== 2'd2 || dmem_error !== 1'b1 || valM !== 64'd0) begin
         $display("FAIL sticky_hold got=%0d/%b/%0h exp=2/1/0", stat, dmem_error, valM); failures++; end
      // boundary: word 256 is out of range, 255 is the last valid one
      do_reset();
      step(4'd10, 64'd66, 64'd255, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (stat !== 2'd0 || dmem_error !== 1'b0) begin
         $display("FAIL edge_255 got=%0d/%b exp=0/0", stat, dmem_error); failures++; end
      step(4'd5, 64'd0, 64'd5, 11'd0, 1'b0, 1'b1, 1'b1);
`ifdef DMEM_CLEAR_ON_RESET_EN
      checks++; if (valM !== 64'd0) begin $display("FAIL sticky_no_write got=%0d exp=0", valM); failures++; end
`else
      checks++; if (valM !== 64'd30) begin $display("FAIL sticky_no_write got=%0d exp=30", valM); failures++; end
`endif
      step(4'd5, 64'd0, 64'd256, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (stat !== 2'd2 || dmem_error !== 1'b1) begin
         $display("FAIL edge_256 got=%0d/%b exp=2/1", stat, dmem_error); failures++; end
      do_reset();
      step(4'd5, 64'd0, 64'h1_0000_0005, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (dmem_error !== 1'b1 || valM !== 64'd0) begin
         $display("FAIL high_bits_oob got=%b/%0h exp=1/0", dmem_error, valM); failures++; end
   endtask

   task automatic test_status_priority();
      do_reset();
      step(4'd0, 64'd0, 64'd0, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (stat !== 2'd1) begin $display("FAIL prio_halt got=%0d exp=1", stat); failures++; end
      do_reset();
      step(4'd1, 64'd0, 64'd0, 11'd0, 1'b0, 1'b0, 1'b1);
      checks++; if (stat !== 2'd3) begin $display("FAIL prio_ins got=%0d exp=3", stat); failures++; end
      do_reset();
      step(4'd0, 64'd0, 64'd0, 11'd0, 1'b1, 1'b0, 1'b1);
      checks++; if (stat !== 2'd2) begin $display("FAIL prio_imem got=%0d exp=2", stat); failures++; end
      do_reset();
      step(4'd4, 64'd123, 64'd5, 11'd0, 1'b0, 1'b0, 1'b1);
      checks++; if (stat !== 2'd3) begin $display("FAIL prio_ins_write got=%0d exp=3", stat); failures++; end
      do_reset();
      step(4'd5, 64'd0, 64'd5, 11'd0, 1'b0, 1'b1, 1'b1);
`ifdef DMEM_CLEAR_ON_RESET_EN
      checks++; if (valM !== 64'd0) begin $display("FAIL ins_no_write got=%0d exp=0", valM); failures++; end
`else
      checks++; if (valM !== 64'd30) begin $display("FAIL ins_no_write got=%0d exp=30", valM); failures++; end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(4'd4, 64'd44, 64'd9, 11'd0, 1'b0, 1'b1, 1'b1);
      step(4'd5, 64'd0, 64'd9, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== 64'd44) begin $display("FAIL mid_setup got=%0d exp=44", valM); failures++; end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (valM !== 64'd0 || stat !== 2'd0 || dmem_error !== 1'b0) begin
         $display("FAIL mid_async_clear got=%0h/%0d/%b exp=0/0/0", valM, stat, dmem_error); failures++; end
      icode = 4'd4; valA = 64'd55; valE = 64'd9; imem_error = 1'b0; instr_valid = 1'b1; e_com = 1'b1;
      @(posedge clk);
      #1;
      e_com = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(4'd5, 64'd0, 64'd9, 11'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (valM !== exp_valm) begin $display("FAIL reset_edge_no_write got=%0d exp=%0d", valM, exp_valm); failures++; end
   endtask

   task automatic test_random();
      logic [3:0]  ic;
      logic [63:0] a, e;
      logic [10:0] p;
      logic        ime, iv, ec;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (exp_stat != 2'd0 && ($urandom % 3 == 0)) do_reset();
         ic  = 4'($urandom_range(0, 15));
         a   = ($urandom % 8 == 0) ? {32'($urandom), 32'($urandom)} | 64'd256 : 64'($urandom_range(0, 15));
         e   = ($urandom % 8 == 0) ? 64'd256 + 64'($urandom_range(0, 1000)) : 64'($urandom_range(0, 15));
         if (ic == 4'd4 || ic == 4'd10) a = {32'($urandom), 32'($urandom)};
         p   = 11'($urandom);
         ime = ($urandom % 25 == 0);
         iv  = ($urandom % 15 != 0);
         ec  = ($urandom % 5 != 0);
         step(ic, a, e, p, ime, iv, ec);
         checks++; if (stat !== exp_stat) begin
            $display("FAIL rand_stat n=%0d got=%0d exp=%0d", n, stat, exp_stat); failures++; end
         checks++; if (dmem_error !== exp_derr) begin
            $display("FAIL rand_dmem_error n=%0d got=%b exp=%b", n, dmem_error, exp_derr); failures++; end
         if (exp_valm_known) begin
            checks++; if (valM !== exp_valm) begin
               $display("FAIL rand_valM n=%0d got=%0h exp=%0h", n, valM, exp_valm); failures++; end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_call_ret();
      test_strobe_gating();
      test_addr_error();
      test_status_priority();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
